spi_cmd_master: RTL and testbench

SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sclk_div.sv | 33 +++
 rtl/spi_cmd_master.sv | 104 ++++++++++
 tb/tb_spi_cmd_master.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and frame constants for the SPI command master
package spi_pkg;

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, WAIT_RDY, READ, CS_HOLD} state_t;

    localparam int WR_BITS      = 32;
    localparam int RD_HDR_BITS  = 24;
    localparam int RD_DATA_BITS = 8;

    function automatic logic [23:0] frame_hdr(input logic rw_n, input logic [16:0] addr);
        return {rw_n, 6'b0, addr};
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// spi_sclk_div: mode-0 SCLK generator, DIV cycles low then DIV high, with edge strobes
module spi_sclk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt;
    logic       last;

    assign last = cnt == 8'(DIV - 1);
    assign rise = en && last && !sclk;
    assign fall = en && last && sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            cnt  <= last ? '0 : cnt + 8'd1;
            sclk <= last ? !sclk : sclk;
        end
    end

endmodule

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI mode-0 initiator for the spi_bridge read/write command frame
module spi_cmd_master
    import spi_pkg::*;
#(
    parameter int SCLK_DIV = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic        clk_sys_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_rw_ni,
    input  logic [16:0] cmd_addr_i,
    input  logic [7:0]  cmd_data_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_err_o,
    output logic        spi_sclk_o,
    output logic        spi_cs_no,
    output logic        spi_tx_o,
    input  logic        spi_rx_i,
    input  logic        spi_ready_ni
);

    localparam int TW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;

    state_t        state, state_nx;
    logic [TW-1:0] tmr;
    logic [5:0]    bit_cnt;
    logic [31:0]   sr;
    logic [7:0]    rd;
    logic [1:0]    rdy_sync;
    logic          rw, err, ready, accept, rise, fall;
    logic          phase_done, timed_out, hdr_done, rd_done;

    spi_sclk_div #(.DIV(SCLK_DIV)) u_div (
        .clk  (clk_sys_i),
        .rst  (reset_i),
        .en   (state == SHIFT || state == READ),
        .sclk (spi_sclk_o),
        .rise (rise),
        .fall (fall)
    );

    assign ready       = !rdy_sync[1];
    assign cmd_ready_o = state == IDLE;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign phase_done  = tmr == TW'(SCLK_DIV - 1);
    assign timed_out   = tmr == TW'(TIMEOUT - 1);
    assign hdr_done    = fall && bit_cnt == (rw ? 6'(RD_HDR_BITS - 1) : 6'(WR_BITS - 1));
    assign rd_done     = fall && bit_cnt == 6'(RD_DATA_BITS - 1);
    assign spi_cs_no   = state == IDLE || state == CS_HOLD;
    assign spi_tx_o    = sr[31] && (state == CS_SETUP || state == SHIFT);
    assign rsp_data_o  = rd;
    assign rsp_err_o   = err;

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = CS_SETUP;
            CS_SETUP: if (phase_done) state_nx = SHIFT;
            SHIFT:    if (hdr_done) state_nx = WAIT_RDY;
            WAIT_RDY: state_nx = ready ? (rw ? READ : CS_HOLD) : timed_out ? CS_HOLD : WAIT_RDY;
            READ:     if (rd_done) state_nx = CS_HOLD;
            CS_HOLD:  if (phase_done) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // One timer serves setup/hold spacing and the ready timeout; it restarts on every state change
    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            tmr         <= '0;
            bit_cnt     <= '0;
            sr          <= '0;
            rd          <= '0;
            rw          <= 1'b0;
            err         <= 1'b0;
            rsp_valid_o <= 1'b0;
            rdy_sync    <= 2'b11;
        end else begin
            rdy_sync    <= {rdy_sync[0], spi_ready_ni};
            tmr         <= state_nx != state ? '0 : tmr + 1'b1;
            bit_cnt     <= state_nx != state ? '0 : bit_cnt + 6'(fall);
            rsp_valid_o <= state == CS_HOLD && phase_done;
            if (accept) begin
                rw  <= cmd_rw_ni;
                sr  <= {frame_hdr(cmd_rw_ni, cmd_addr_i), cmd_rw_ni ? 8'h00 : cmd_data_i};
                rd  <= '0;
                err <= 1'b0;
            end else if (fall && state == SHIFT) begin
                sr <= {sr[30:0], 1'b0};
            end
            if (rise && state == READ) rd <= {rd[6:0], spi_rx_i};
            if (state == WAIT_RDY && !ready && timed_out) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: table-driven and randomized checks against a frame-level SPI responder model
module tb_spi_cmd_master;

    localparam int DIV = 2;
    localparam int TMO = 16;

    typedef struct {
        logic        rw;
        logic [16:0] addr;
        logic [7:0]  data;
        logic [7:0]  miso;
        int          rdy;
        logic [31:0] exp_mosi;
        logic        exp_err;
        logic [7:0]  exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_rw_ni = 1'b0;
    logic [16:0] cmd_addr_i = '0;
    logic [7:0]  cmd_data_i = '0;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_err_o;
    logic        spi_sclk_o;
    logic        spi_cs_no;
    logic        spi_tx_o;
    logic        spi_rx_i = 1'b0;
    logic        spi_ready_ni = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [31:0] mosi = '0;
    int          nbits = 0;
    logic [7:0]  miso_byte = '0;
    logic        cur_rw = 1'b0;
    int          rdy_delay = -1;
    int          wcnt = 0;
    int          cs_low_run = 0, cs_high_run = 0, last_cs_low = 0, last_gap = 0;
    int          sclk_hi = 0, sclk_bad = 0, idle_bad = 0, rsp_cnt = 0;

    spi_cmd_master #(.SCLK_DIV(DIV), .TIMEOUT(TMO)) dut (
        .clk_sys_i    (clk),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_rw_ni    (cmd_rw_ni),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_data_i   (cmd_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .spi_sclk_o   (spi_sclk_o),
        .spi_cs_no    (spi_cs_no),
        .spi_tx_o     (spi_tx_o),
        .spi_rx_i     (spi_rx_i),
        .spi_ready_ni (spi_ready_ni)
    );

    always #5 clk = ~clk;

    // Responder: captures MOSI on SCLK rise, presents the read byte after each fall
    always @(posedge spi_sclk_o or negedge spi_cs_no) begin
        if (spi_sclk_o) begin
            mosi  = {mosi[30:0], spi_tx_o};
            nbits = nbits + 1;
        end else begin
            mosi  = '0;
            nbits = 0;
        end
    end

    always @(negedge spi_sclk_o)
        spi_rx_i = (nbits >= 24 && nbits < 32) ? miso_byte[31 - nbits] : 1'b0;

    // Ready drops rdy_delay cycles after the header is clocked out (0: always ready, <0: never)
    always @(negedge clk) begin
        if (spi_cs_no) wcnt = 0;
        else if (nbits >= (cur_rw ? 24 : 32)) wcnt = wcnt + 1;
        spi_ready_ni = !(rdy_delay == 0 || (rdy_delay > 0 && wcnt >= rdy_delay));
    end

    always @(negedge clk) begin
        if (spi_cs_no) begin
            if (cs_low_run > 0) begin last_cs_low = cs_low_run; cs_low_run = 0; end
            if (sclk_hi > 0) begin if (sclk_hi != DIV) sclk_bad++; sclk_hi = 0; end
            cs_high_run++;
            if (spi_tx_o !== 1'b0 || spi_sclk_o !== 1'b0) idle_bad++;
        end else begin
            if (cs_high_run > 0) begin last_gap = cs_high_run; cs_high_run = 0; end
            cs_low_run++;
            if (spi_sclk_o) sclk_hi++;
            else if (sclk_hi > 0) begin if (sclk_hi != DIV) sclk_bad++; sclk_hi = 0; end
        end
        if (rsp_valid_o) rsp_cnt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic rw, input logic [16:0] addr, input logic [7:0] data,
                                   input logic [7:0] miso, input int rdy);
        vec_t v;
        logic [23:0] hdr;
        hdr = {rw, 6'b0, addr};
        v.rw = rw; v.addr = addr; v.data = data; v.miso = miso; v.rdy = rdy;
        v.exp_err  = rdy < 0;
        v.exp_mosi = !rw ? {hdr, data} : (rdy < 0 ? {8'h00, hdr} : {hdr, 8'h00});
        v.exp_data = (rw && rdy >= 0) ? miso : 8'h00;
        return v;
    endfunction

    task automatic run_cmd(input vec_t v, input bit glitch);
        int k, base, rsp0;
        bit to, pulsed;
        to = v.rdy < 0;
        base = DIV + (v.rw ? 24 : 32) * 2 * DIV + ((v.rw && !to) ? 16 * DIV : 0);
        @(negedge clk);
        cur_rw = v.rw; miso_byte = v.miso; rdy_delay = v.rdy;
        cmd_rw_ni = v.rw; cmd_addr_i = v.addr; cmd_data_i = v.data; cmd_valid_i = 1'b1;
        k = 0;
        while (!cmd_ready_o && k < 1000) begin @(negedge clk); k++; end
        chk("accept", 32'(cmd_ready_o), 32'd1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0; cmd_rw_ni = ~v.rw; cmd_addr_i = 17'($urandom); cmd_data_i = 8'($urandom);
        sclk_bad = 0; idle_bad = 0; rsp0 = rsp_cnt; pulsed = 0;
        k = 0;
        do begin
            @(negedge clk); k++;
            if (cmd_valid_i) cmd_valid_i = 1'b0;
            if (glitch && !pulsed && nbits == 5) begin cmd_valid_i = 1'b1; cmd_rw_ni = 1'b1; pulsed = 1; end
        end while (!rsp_valid_o && k < 3000);
        chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("rsp_err", 32'(rsp_err_o), 32'(v.exp_err));
        if (v.rw || to) chk("rsp_data", 32'(rsp_data_o), 32'(v.exp_data));
        chk("mosi", mosi, v.exp_mosi);
        chk("nbits", nbits, (v.rw && to) ? 24 : 32);
        chk("cs_high_at_rsp", 32'(spi_cs_no), 32'd1);
        if (v.rdy == 0) chk("cs_len", last_cs_low, base + 1);
        else if (to) chk("cs_len_timeout", last_cs_low, base + TMO);
        else chk("cs_len_range", 32'(last_cs_low > base && last_cs_low <= base + v.rdy + 3), 32'd1);
        chk("sclk_high_runs_bad", sclk_bad, 0);
        chk("idle_lines_bad", idle_bad, 0);
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rsp_valid_o), 32'd0);
        chk("rsp_pulses", rsp_cnt - rsp0, 1);
    endtask

    vec_t vecs[5];

    initial begin
        int k, r, rsp0;
        vecs[0] = '{1'b0, 17'h08000, 8'hA5, 8'h00, 10, 32'h008000A5, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 17'h1E80E, 8'h00, 8'h01, 0,  32'h81E80E00, 1'b0, 8'h01};
        vecs[2] = '{1'b0, 17'h1FFFF, 8'h3C, 8'h00, -1, 32'h01FFFF3C, 1'b1, 8'h00};
        vecs[3] = '{1'b1, 17'h00001, 8'h00, 8'h80, -1, 32'h00800001, 1'b1, 8'h00};
        vecs[4] = '{1'b1, 17'h10000, 8'h00, 8'hC3, 5,  32'h81000000, 1'b0, 8'hC3};

        repeat (3) @(negedge clk);
        chk("reset_spi_lines", {29'd0, spi_cs_no, spi_sclk_o, spi_tx_o}, 32'h4);
        chk("reset_handshake", {30'd0, cmd_ready_o, rsp_valid_o}, 32'h2);
        chk("reset_rsp", {23'd0, rsp_err_o, rsp_data_o}, 32'h0);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) run_cmd(vecs[i], 1'b0);

        for (int i = 0; i < 20; i++) begin
            r = int'($urandom_range(0, 9));
            run_cmd(model(1'($urandom), 17'($urandom), 8'($urandom), 8'($urandom),
                          r == 0 ? -1 : r < 4 ? 0 : int'($urandom_range(1, 8))), 1'b0);
        end

        // Back-to-back writes with cmd_valid held high
        cur_rw = 1'b0; rdy_delay = 0; miso_byte = 8'h00;
        @(negedge clk);
        cmd_rw_ni = 1'b0; cmd_addr_i = 17'h0ABCD; cmd_data_i = 8'h11; cmd_valid_i = 1'b1;
        k = 0;
        while (!cmd_ready_o && k < 1000) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        cmd_addr_i = 17'h15555; cmd_data_i = 8'hEE;
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp_valid_o && k < 3000);
        chk("b2b_first_rsp", 32'(rsp_valid_o), 32'd1);
        chk("b2b_ready_on_rsp", 32'(cmd_ready_o), 32'd1);
        chk("b2b_first_mosi", mosi, 32'h00ABCD11);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_second_accepted", 32'(cmd_ready_o), 32'd0);
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp_valid_o && k < 3000);
        chk("b2b_second_rsp", 32'(rsp_valid_o), 32'd1);
        chk("b2b_second_mosi", mosi, 32'h015555EE);
        chk("b2b_cs_gap", 32'(last_gap >= DIV), 32'd1);
        repeat (3) @(negedge clk);

        // Reset in the middle of a write frame
        @(negedge clk);
        cmd_rw_ni = 1'b0; cmd_addr_i = 17'h13579; cmd_data_i = 8'h5A; cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        k = 0;
        while (nbits < 12 && k < 1000) begin @(negedge clk); k++; end
        chk("abort_reached_bit12", 32'(nbits), 32'd12);
        rsp0 = rsp_cnt;
        #2 reset_i = 1'b1;
        #1 chk("abort_lines_immediate", {30'd0, spi_cs_no, spi_sclk_o}, 32'h2);
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_rsp", rsp_cnt - rsp0, 0);
        chk("abort_cs_high", 32'(spi_cs_no), 32'd1);
        run_cmd(model(1'b1, 17'h0C0DE, 8'h00, 8'h96, 0), 1'b0);

        // Ready already asserted, with a stray cmd_valid pulse during SHIFT
        run_cmd(model(1'b0, 17'h1A5A5, 8'h7E, 8'h00, 0), 1'b1);
        repeat (20) @(negedge clk);
        chk("no_extra_frame", 32'(cs_high_run >= 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
